// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, ACK/NACK line levels and bit-order helper.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_BYTE,
    RX_ACK,
    TX_BYTE,
    TX_ACK,
    IGNORE
  } i2c_slave_state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  function automatic logic [2:0] bit_pos(input logic msb_first, input logic [2:0] cnt);
    return msb_first ? (3'd7 - cnt) : cnt;
  endfunction

endpackage

// File: rtl/i2c_sync.sv
// Multi-flop synchronizer for one bus line with rise/fall detect; preset to 1 (idle bus).
// Level lags the pin by STAGES cycles; edge strobes are single-cycle on the synchronized value.
module i2c_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic arstn,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge arstn) begin
    if (arstn) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], line};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: 7-bit address match, byte write/read, open-drain sda (0 or Z only), no clock stretching.
// Bits sampled on synchronized scl rise; sda drive updates the cycle after a synchronized scl fall.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h34,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       arstn,
  input  logic       scl,
  inout  wire        sda,
  input  logic       msb_lsb,
  input  logic [7:0] byte_2_send,
  output logic [7:0] byte_received,
  output logic       rx_valid,
  output logic       tx_load,
  output logic       nack_rcvd,
  output logic       busy,
  output logic       rw
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .arstn(arstn), .line(scl),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .arstn(arstn), .line(sda),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  i2c_slave_state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       msb_q, msb_d;
  logic       oe_q, oe_d;
  logic       rw_d, busy_d;
  logic [7:0] rx_byte_d;
  logic       rx_valid_d, tx_load_d, nack_d;
  logic [2:0] pos;
  logic [7:0] sampled;
  logic       start_cond, stop_cond;

  assign start_cond = sda_fall & scl_lvl;
  assign stop_cond  = sda_rise & scl_lvl;

  // Open-drain: oe pulls the line low, otherwise it floats
  assign sda = oe_q ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge arstn) begin
    if (arstn) begin
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      shreg_q       <= 8'h00;
      msb_q         <= 1'b1;
      oe_q          <= 1'b0;
      rw            <= 1'b0;
      busy          <= 1'b0;
      byte_received <= 8'h00;
      rx_valid      <= 1'b0;
      tx_load       <= 1'b0;
      nack_rcvd     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shreg_q       <= shreg_d;
      msb_q         <= msb_d;
      oe_q          <= oe_d;
      rw            <= rw_d;
      busy          <= busy_d;
      byte_received <= rx_byte_d;
      rx_valid      <= rx_valid_d;
      tx_load       <= tx_load_d;
      nack_rcvd     <= nack_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    msb_d      = msb_q;
    oe_d       = oe_q;
    rw_d       = rw;
    busy_d     = busy;
    rx_byte_d  = byte_received;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    nack_d     = 1'b0;
    pos        = bit_pos(msb_q, cnt_q);
    sampled    = shreg_q;
    sampled[pos] = sda_lvl;

    if (start_cond) begin
      state_d = ADDR;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      msb_d   = msb_lsb;
    end else if (stop_cond) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shreg_d = sampled;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (sampled[7:1] == SLAVE_ADDR) begin
                rw_d    = sampled[0];
                busy_d  = 1'b1;
                state_d = ADDR_ACK;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end
        // cnt 0: waiting for the 8th fall to start ACK; cnt 1: waiting for the 9th fall
        ADDR_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              oe_d  = (ACK == 1'b0);
              cnt_d = 3'd1;
            end else begin
              cnt_d = 3'd0;
              if (rw) begin
                tx_load_d = 1'b1;
                shreg_d   = byte_2_send;
                oe_d      = ~byte_2_send[bit_pos(msb_q, 3'd0)];
                state_d   = TX_BYTE;
              end else begin
                oe_d    = 1'b0;
                state_d = RX_BYTE;
              end
            end
          end
        end
        RX_BYTE: begin
          if (scl_rise) begin
            shreg_d = sampled;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_byte_d  = sampled;
              rx_valid_d = 1'b1;
              state_d    = RX_ACK;
            end
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              oe_d  = (ACK == 1'b0);
              cnt_d = 3'd1;
            end else begin
              oe_d    = 1'b0;
              cnt_d   = 3'd0;
              state_d = RX_BYTE;
            end
          end
        end
        // cnt wraps to 0 on the 8th rise, so the following fall ends the byte
        TX_BYTE: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
          end else if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              oe_d    = 1'b0;
              state_d = TX_ACK;
            end else begin
              oe_d = ~shreg_q[pos];
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (sda_lvl == NACK) begin
              nack_d  = 1'b1;
              state_d = IGNORE;
            end else begin
              cnt_d = 3'd1;
            end
          end else if (scl_fall && cnt_q == 3'd1) begin
            cnt_d     = 3'd0;
            tx_load_d = 1'b1;
            shreg_d   = byte_2_send;
            oe_d      = ~byte_2_send[bit_pos(msb_q, 3'd0)];
            state_d   = TX_BYTE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged open-drain master with hand-computed expectations.
module tb_i2c_slave;

  localparam int Q = 100;

  logic       clk = 1'b0;
  logic       arstn = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic       msb_lsb = 1'b1;
  logic [7:0] byte_2_send = 8'h00;
  logic [7:0] byte_received;
  logic       rx_valid, tx_load, nack_rcvd, busy, rw;
  wire        sda;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave #(.SLAVE_ADDR(7'h34), .SYNC_STAGES(2)) dut (
    .clk(clk), .arstn(arstn), .scl(scl), .sda(sda), .msb_lsb(msb_lsb),
    .byte_2_send(byte_2_send), .byte_received(byte_received),
    .rx_valid(rx_valid), .tx_load(tx_load), .nack_rcvd(nack_rcvd),
    .busy(busy), .rw(rw)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_rx = 0, n_tx = 0, n_nack = 0, n_drv = 0, n_busy = 0;
  int b_rx, b_tx, b_nack, b_drv, b_busy;

  always @(negedge clk) begin
    if (rx_valid)  n_rx++;
    if (tx_load)   n_tx++;
    if (nack_rcvd) n_nack++;
    if (busy)      n_busy++;
    if (!m_low && sda !== 1'b1) n_drv++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic base();
    b_rx = n_rx; b_tx = n_tx; b_nack = n_nack; b_drv = n_drv; b_busy = n_busy;
  endtask

  function automatic int bpos(input int i);
    return msb_lsb ? 7 - i : i;
  endfunction

  task automatic clk_bit(input logic b, output logic r);
    m_low = ~b;
    #Q; scl = 1'b1;
    #Q; r = sda;
    #Q; scl = 1'b0;
    #Q;
  endtask

  task automatic bus_start();
    m_low = 1'b0;
    #Q; scl = 1'b1;
    #Q; m_low = 1'b1;
    #Q; scl = 1'b0;
    #Q;
  endtask

  task automatic bus_stop();
    m_low = 1'b1;
    #Q; scl = 1'b1;
    #Q; m_low = 1'b0;
    #Q;
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    logic r;
    for (int i = 0; i < 8; i++) clk_bit(v[bpos(i)], r);
    clk_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic master_nack, output logic [7:0] v);
    logic r;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, r);
      v[bpos(i)] = r;
    end
    clk_bit(master_nack, r);
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] v;

    // reset state
    #33;
    chk("rst_sda", {31'd0, sda}, 32'd1);
    chk("rst_byte", {24'd0, byte_received}, 32'h00);
    chk("rst_pulses", {29'd0, rx_valid, tx_load, nack_rcvd}, 32'd0);
    chk("rst_busy_rw", {30'd0, busy, rw}, 32'd0);
    arstn = 1'b0;
    #50;

    // write 8'h34 to 7'h34, MSB first
    base();
    bus_start();
    send_byte(8'h68, ack);
    chk("w_addr_ack", {31'd0, ack}, 32'd0);
    chk("w_busy", {31'd0, busy}, 32'd1);
    chk("w_rw", {31'd0, rw}, 32'd0);
    send_byte(8'h34, ack);
    chk("w_data_ack", {31'd0, ack}, 32'd0);
    chk("w_byte", {24'd0, byte_received}, 32'h34);
    chk("w_rx_cnt", n_rx - b_rx, 32'd1);
    chk("w_busy_pre_stop", {31'd0, busy}, 32'd1);
    bus_stop();
    chk("w_busy_stop", {31'd0, busy}, 32'd0);
    chk("w_tx_cnt", n_tx - b_tx, 32'd0);

    // read 8'h29 from 7'h34, master NACKs
    base();
    byte_2_send = 8'h29;
    bus_start();
    send_byte(8'h69, ack);
    chk("r_addr_ack", {31'd0, ack}, 32'd0);
    chk("r_rw", {31'd0, rw}, 32'd1);
    recv_byte(1'b1, v);
    chk("r_data", {24'd0, v}, 32'h29);
    chk("r_tx_cnt", n_tx - b_tx, 32'd1);
    chk("r_nack_cnt", n_nack - b_nack, 32'd1);
    chk("r_rx_cnt", n_rx - b_rx, 32'd0);
    bus_stop();
    chk("r_busy_stop", {31'd0, busy}, 32'd0);

    // foreign address 7'h35: no drive, no pulses, never busy
    base();
    bus_start();
    send_byte(8'h6A, ack);
    chk("x_addr_nack", {31'd0, ack}, 32'd1);
    send_byte(8'hA5, ack);
    chk("x_data_nack", {31'd0, ack}, 32'd1);
    bus_stop();
    chk("x_drv", n_drv - b_drv, 32'd0);
    chk("x_pulses", (n_rx - b_rx) + (n_tx - b_tx) + (n_nack - b_nack), 32'd0);
    chk("x_busy", n_busy - b_busy, 32'd0);
    chk("x_byte_held", {24'd0, byte_received}, 32'h34);

    // LSB first: write 8'h01, then read 8'h80
    msb_lsb = 1'b0;
    bus_start();
    send_byte(8'h68, ack);
    chk("l_waddr_ack", {31'd0, ack}, 32'd0);
    send_byte(8'h01, ack);
    chk("l_wdata_ack", {31'd0, ack}, 32'd0);
    chk("l_byte", {24'd0, byte_received}, 32'h01);
    bus_stop();
    byte_2_send = 8'h80;
    bus_start();
    send_byte(8'h69, ack);
    chk("l_raddr_ack", {31'd0, ack}, 32'd0);
    recv_byte(1'b1, v);
    chk("l_rdata", {24'd0, v}, 32'h80);
    bus_stop();
    msb_lsb = 1'b1;

    // repeated START after 4 data bits, then read
    base();
    bus_start();
    send_byte(8'h68, ack);
    chk("rs_waddr_ack", {31'd0, ack}, 32'd0);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, r);
    byte_2_send = 8'h5A;
    bus_start();
    send_byte(8'h69, ack);
    chk("rs_raddr_ack", {31'd0, ack}, 32'd0);
    chk("rs_rw", {31'd0, rw}, 32'd1);
    chk("rs_busy", {31'd0, busy}, 32'd1);
    chk("rs_no_rx", n_rx - b_rx, 32'd0);
    chk("rs_byte_held", {24'd0, byte_received}, 32'h01);
    recv_byte(1'b1, v);
    chk("rs_rdata", {24'd0, v}, 32'h5A);
    bus_stop();

    // reset during the 3rd bit of a read byte
    byte_2_send = 8'h00;
    bus_start();
    send_byte(8'h69, ack);
    chk("ar_addr_ack", {31'd0, ack}, 32'd0);
    clk_bit(1'b1, r);
    clk_bit(1'b1, r);
    m_low = 1'b0;
    #Q; scl = 1'b1;
    #(Q/2);
    chk("ar_drv_before", {31'd0, sda}, 32'd0);
    arstn = 1'b1;
    #1;
    chk("ar_sda_rel", {31'd0, sda}, 32'd1);
    chk("ar_outs", {21'd0, byte_received, rx_valid, tx_load, nack_rcvd}, 32'd0);
    chk("ar_busy_rw", {30'd0, busy, rw}, 32'd0);
    #20;
    arstn = 1'b0;
    base();
    #(Q/2); scl = 1'b0;
    #Q;
    for (int i = 0; i < 6; i++) clk_bit(1'b1, r);
    chk("ar_no_drv", n_drv - b_drv, 32'd0);
    chk("ar_no_pulse", (n_rx - b_rx) + (n_tx - b_tx) + (n_nack - b_nack), 32'd0);
    bus_stop();
    bus_start();
    send_byte(8'h68, ack);
    chk("ar_new_ack", {31'd0, ack}, 32'd0);
    send_byte(8'h77, ack);
    chk("ar_new_byte", {24'd0, byte_received}, 32'h77);
    bus_stop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
